// File: rtl/calibration_pkg.sv
// Types, ASCII constants and the digit-word table used by the calibration line decoder.
package calibration_pkg;

  typedef enum logic [1:0] {
    READING,
    LINE_END,
    DONE
  } state_t;

  localparam logic [7:0] ZERO = 8'd48;
  localparam logic [7:0] NINE = 8'd57;
  localparam logic [7:0] LF   = 8'd10;

  // Words are right-aligned so the final letter lands in the low byte,
  // lining up with the byte currently being presented.
  function automatic logic [39:0] digit_word(input logic [3:0] d);
    case (d)
      4'd1:    digit_word = {16'h0, "one"};
      4'd2:    digit_word = {16'h0, "two"};
      4'd3:    digit_word = "three";
      4'd4:    digit_word = {8'h0, "four"};
      4'd5:    digit_word = {8'h0, "five"};
      4'd6:    digit_word = {16'h0, "six"};
      4'd7:    digit_word = "seven";
      4'd8:    digit_word = "eight";
      4'd9:    digit_word = {8'h0, "nine"};
      default: digit_word = '0;
    endcase
  endfunction

  function automatic logic [2:0] digit_word_len(input logic [3:0] d);
    case (d)
      4'd1, 4'd2, 4'd6: digit_word_len = 3'd3;
      4'd4, 4'd5, 4'd9: digit_word_len = 3'd4;
      4'd3, 4'd7, 4'd8: digit_word_len = 3'd5;
      default:          digit_word_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/digit_word_matcher.sv
// Flags a lowercase digit word ending on the current byte, using the last four
// bytes of the line; hit/digit are combinational on char_i.
module digit_word_matcher
  import calibration_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       shift_i,
  input  logic [7:0] char_i,
  output logic       hit_o,
  output logic [3:0] digit_o
);

  logic [31:0] hist_q, hist_d;
  logic [39:0] window;
  logic [39:0] mask;

  assign window = {hist_q, char_i};

  always_comb begin
    hist_d = hist_q;
    if (clr_i) begin
      hist_d = '0;
    end else if (shift_i) begin
      hist_d = {hist_q[23:0], char_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Cleared history bytes are zero, which never matches a letter.
  always_comb begin
    hit_o   = 1'b0;
    digit_o = '0;
    mask    = '0;
    for (int k = 1; k <= 9; k++) begin
      mask = ~40'h0 >> (8 * (5 - int'(digit_word_len(4'(k)))));
      if ((window & mask) == digit_word(4'(k))) begin
        hit_o   = 1'b1;
        digit_o = 4'(k);
      end
    end
  end

endmodule

// File: rtl/calibration_sum_stream.sv
// Streaming calibration decoder: first*10+last digit per line, one record per line,
// running total with sticky carry-out; stalls input for the single line-close cycle.
module calibration_sum_stream
  import calibration_pkg::*;
#(
  parameter int RESULT_W   = 32,
  parameter int LINE_CNT_W = 16,
  parameter bit WORD_MODE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            char_in,
  input  logic                  in_last,
  output logic                  line_valid,
  output logic [6:0]            line_value,
  output logic                  line_has_dig,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic [RESULT_W-1:0]   result,
  output logic                  overflow,
  output logic                  done
);

  state_t                state_q, state_d;
  logic                  finish_q, finish_d;
  logic [3:0]            first_q, first_d;
  logic [3:0]            last_q, last_d;
  logic                  found_q, found_d;
  logic                  line_valid_q, line_valid_d;
  logic [6:0]            line_value_q, line_value_d;
  logic                  has_dig_q, has_dig_d;
  logic [LINE_CNT_W-1:0] count_q, count_d;
  logic [RESULT_W-1:0]   result_q, result_d;
  logic                  overflow_q, overflow_d;

  logic                  accept;
  logic                  is_num;
  logic                  word_hit;
  logic [3:0]            word_digit;
  logic                  digit_hit;
  logic [3:0]            digit_val;
  logic [6:0]            line_sum;
  logic [RESULT_W:0]     sum_ext;

  assign in_ready = (state_q == READING);
  assign done     = (state_q == DONE);
  assign accept   = in_valid & in_ready;
  assign is_num   = (char_in >= ZERO) && (char_in <= NINE);

  generate
    if (WORD_MODE) begin : g_word
      digit_word_matcher u_matcher (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == LINE_END),
        .shift_i (accept && (char_in != LF)),
        .char_i  (char_in),
        .hit_o   (word_hit),
        .digit_o (word_digit)
      );
    end else begin : g_no_word
      assign word_hit   = 1'b0;
      assign word_digit = '0;
    end
  endgenerate

  // ASCII numerals 0x30..0x39 carry their value in the low nibble.
  assign digit_hit = accept && (is_num || word_hit);
  assign digit_val = is_num ? char_in[3:0] : word_digit;
  assign line_sum  = {3'b000, first_q} * 7'd10 + {3'b000, last_q};
  assign sum_ext   = {1'b0, result_q} + {{(RESULT_W - 6){1'b0}}, line_sum};

  always_comb begin
    state_d      = state_q;
    finish_d     = finish_q;
    first_d      = first_q;
    last_d       = last_q;
    found_d      = found_q;
    line_valid_d = 1'b0;
    line_value_d = line_value_q;
    has_dig_d    = has_dig_q;
    count_d      = count_q;
    result_d     = result_q;
    overflow_d   = overflow_q;
    case (state_q)
      READING: begin
        if (digit_hit) begin
          if (!found_q) begin
            first_d = digit_val;
          end
          last_d  = digit_val;
          found_d = 1'b1;
        end
        if (accept && ((char_in == LF) || in_last)) begin
          state_d  = LINE_END;
          finish_d = in_last;
        end
      end
      LINE_END: begin
        line_valid_d = 1'b1;
        count_d      = count_q + LINE_CNT_W'(1);
        if (found_q) begin
          line_value_d = line_sum;
          has_dig_d    = 1'b1;
          result_d     = sum_ext[RESULT_W-1:0];
          overflow_d   = overflow_q | sum_ext[RESULT_W];
        end else begin
          line_value_d = '0;
          has_dig_d    = 1'b0;
        end
        first_d = '0;
        last_d  = '0;
        found_d = 1'b0;
        state_d = finish_q ? DONE : READING;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = READING;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= READING;
      finish_q     <= 1'b0;
      first_q      <= '0;
      last_q       <= '0;
      found_q      <= 1'b0;
      line_valid_q <= 1'b0;
      line_value_q <= '0;
      has_dig_q    <= 1'b0;
      count_q      <= '0;
      result_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      finish_q     <= finish_d;
      first_q      <= first_d;
      last_q       <= last_d;
      found_q      <= found_d;
      line_valid_q <= line_valid_d;
      line_value_q <= line_value_d;
      has_dig_q    <= has_dig_d;
      count_q      <= count_d;
      result_q     <= result_d;
      overflow_q   <= overflow_d;
    end
  end

  assign line_valid   = line_valid_q;
  assign line_value   = line_value_q;
  assign line_has_dig = has_dig_q;
  assign line_count   = count_q;
  assign result       = result_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_calibration_sum_stream.sv
// Bench for calibration_sum_stream: three configurations share one byte stream and
// are compared against a line-string reference model plus directed expected values.
module tb_calibration_sum_stream;

  localparam logic [7:0] LF = 8'd10;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_last;
  logic [7:0] char_in;

  logic        in_ready_a, line_valid_a, line_has_dig_a, overflow_a, done_a;
  logic [6:0]  line_value_a;
  logic [15:0] line_count_a;
  logic [31:0] result_a;
  logic        in_ready_b, line_valid_b, line_has_dig_b, overflow_b, done_b;
  logic [6:0]  line_value_b;
  logic [15:0] line_count_b;
  logic [31:0] result_b;
  logic        in_ready_c, line_valid_c, line_has_dig_c, overflow_c, done_c;
  logic [6:0]  line_value_c;
  logic [15:0] line_count_c;
  logic [7:0]  result_c;

  always #5 clk = ~clk;

  calibration_sum_stream #(.RESULT_W(32), .LINE_CNT_W(16), .WORD_MODE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .char_in(char_in),
    .in_last(in_last), .line_valid(line_valid_a), .line_value(line_value_a),
    .line_has_dig(line_has_dig_a), .line_count(line_count_a), .result(result_a),
    .overflow(overflow_a), .done(done_a));

  calibration_sum_stream #(.RESULT_W(32), .LINE_CNT_W(16), .WORD_MODE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .char_in(char_in),
    .in_last(in_last), .line_valid(line_valid_b), .line_value(line_value_b),
    .line_has_dig(line_has_dig_b), .line_count(line_count_b), .result(result_b),
    .overflow(overflow_b), .done(done_b));

  calibration_sum_stream #(.RESULT_W(8), .LINE_CNT_W(16), .WORD_MODE(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .char_in(char_in),
    .in_last(in_last), .line_valid(line_valid_c), .line_value(line_value_c),
    .line_has_dig(line_has_dig_c), .line_count(line_count_c), .result(result_c),
    .overflow(overflow_c), .done(done_c));

  int total  = 0;
  int passed = 0;
  int failed = 0;

  string      wtab[9] = '{"one", "two", "three", "four", "five", "six", "seven", "eight", "nine"};
  string      pool    = "0123456789onetwhrfuivsxgabz\r";
  logic [7:0] cur[$];
  longint     m_res_a, m_res_b, m_res_c;
  bit         m_ovf_a, m_ovf_b, m_ovf_c;
  int         m_cnt, m_va, m_vb;
  bit         m_fa, m_fb, m_done;
  bit         pend;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scan the whole line text for digits, earliest to latest.
  function automatic void line_eval(input bit wm, output int val, output bit fnd);
    int first = 0;
    int last  = 0;
    fnd = 1'b0;
    for (int i = 0; i < cur.size(); i++) begin
      int d = -1;
      if (cur[i] >= "0" && cur[i] <= "9") begin
        d = int'(cur[i]) - 48;
      end else if (wm) begin
        for (int k = 0; k < 9; k++) begin
          int L = wtab[k].len();
          if (i + 1 >= L) begin
            bit m = 1'b1;
            for (int j = 0; j < L; j++)
              if (cur[i + 1 - L + j] != wtab[k][j]) m = 1'b0;
            if (m) d = k + 1;
          end
        end
      end
      if (d >= 0) begin
        if (!fnd) first = d;
        last = d;
        fnd  = 1'b1;
      end
    end
    val = fnd ? first * 10 + last : 0;
  endfunction

  task automatic model_accept(input logic [7:0] b, input bit last);
    cur.push_back(b);
    if (b == LF || last) begin
      line_eval(1'b1, m_va, m_fa);
      line_eval(1'b0, m_vb, m_fb);
      m_cnt++;
      if (m_fa) begin
        m_res_a += m_va;
        m_res_c += m_va;
        if (m_res_a >= 64'h1_0000_0000) begin m_res_a -= 64'h1_0000_0000; m_ovf_a = 1'b1; end
        if (m_res_c >= 256) begin m_res_c -= 256; m_ovf_c = 1'b1; end
      end
      if (m_fb) begin
        m_res_b += m_vb;
        if (m_res_b >= 64'h1_0000_0000) begin m_res_b -= 64'h1_0000_0000; m_ovf_b = 1'b1; end
      end
      m_done = last;
      cur.delete();
    end
  endtask

  task automatic check_close();
    chk("lv_a", line_valid_a, 1);   chk("lv_b", line_valid_b, 1);   chk("lv_c", line_valid_c, 1);
    chk("val_a", line_value_a, m_va); chk("val_b", line_value_b, m_vb); chk("val_c", line_value_c, m_va);
    chk("has_a", line_has_dig_a, m_fa); chk("has_b", line_has_dig_b, m_fb); chk("has_c", line_has_dig_c, m_fa);
    chk("cnt_a", line_count_a, m_cnt); chk("cnt_b", line_count_b, m_cnt); chk("cnt_c", line_count_c, m_cnt);
    chk("res_a", result_a, m_res_a); chk("res_b", result_b, m_res_b); chk("res_c", result_c, m_res_c);
    chk("ovf_a", overflow_a, m_ovf_a); chk("ovf_b", overflow_b, m_ovf_b); chk("ovf_c", overflow_c, m_ovf_c);
    chk("done_a", done_a, m_done); chk("done_b", done_b, m_done); chk("done_c", done_c, m_done);
    chk("rdy_a", in_ready_a, !m_done); chk("rdy_b", in_ready_b, !m_done); chk("rdy_c", in_ready_c, !m_done);
  endtask

  // One cycle on; the cycle after a line-closing byte carries the record.
  task automatic advance();
    @(negedge clk);
    if (pend) begin
      pend = 1'b0;
      check_close();
    end
  endtask

  task automatic step(input logic [7:0] b, input bit last);
    int stall = 0;
    int want_stall = pend ? 1 : 0;
    in_valid = 1'b1;
    char_in  = b;
    in_last  = last;
    while (in_ready_a !== 1'b1 && stall < 4) begin
      stall++;
      advance();
    end
    chk("stall", stall, want_stall);
    if (in_ready_a === 1'b1) begin
      @(posedge clk);
      model_accept(b, last);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (b == LF || last) begin
        chk("rdy_line_end", in_ready_a, 0);
        pend = 1'b1;
      end else begin
        chk("quiet", line_valid_a, 0);
      end
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send_line(input string s, input bit last_end);
    for (int i = 0; i < s.len(); i++)
      step(s[i], last_end && (i == s.len() - 1));
  endtask

  task automatic do_reset();
    advance();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur.delete();
    m_res_a = 0; m_res_b = 0; m_res_c = 0;
    m_ovf_a = 0; m_ovf_b = 0; m_ovf_c = 0;
    m_cnt = 0; m_done = 0; pend = 0;
    chk("rst_lv", line_valid_a, 0);    chk("rst_val", line_value_a, 0);
    chk("rst_has", line_has_dig_a, 0); chk("rst_cnt", line_count_a, 0);
    chk("rst_res", result_a, 0);       chk("rst_ovf", overflow_a, 0);
    chk("rst_done", done_a, 0);        chk("rst_rdy", in_ready_a, 1);
    chk("rst_res_c", result_c, 0);     chk("rst_rdy_b", in_ready_b, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; char_in = 8'h00; pend = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Numerals only on the WORD_MODE=0 instance.
    send_line("1abc2\n", 1'b0);       advance(); chk("t1_l1", line_value_b, 12);
    send_line("pqr3stu8vwx\n", 1'b0); advance(); chk("t1_l2", line_value_b, 38);
    send_line("a1b2c3d4e5f\n", 1'b0); advance(); chk("t1_l3", line_value_b, 15);
    send_line("treb7uchet\n", 1'b0);  advance(); chk("t1_l4", line_value_b, 77);
    chk("t1_sum", result_b, 142);
    chk("t1_cnt", line_count_b, 4);

    // Spelled digits, including overlapping words.
    send_line("two1nine\n", 1'b0);
    advance(); chk("t2_word", line_value_a, 29); chk("t2_noword", line_value_b, 11);
    send_line("eightwo\n", 1'b0);       advance(); chk("t2_overlap", line_value_a, 82);
    send_line("zoneight234\n", 1'b0);   advance(); chk("t2_zone", line_value_a, 14);
    send_line("7pqrstsixteen\n", 1'b0); advance(); chk("t2_six", line_value_a, 76);

    // Lines without any digit.
    do_reset();
    send_line("\n", 1'b0);    advance(); chk("t3_has0", line_has_dig_a, 0);
    send_line("abc\n", 1'b0); advance(); chk("t3_val0", line_value_a, 0);
    chk("t3_res", result_a, 0);
    chk("t3_cnt", line_count_a, 2);

    // Final byte without newline closes the stream.
    do_reset();
    send_line("4x5", 1'b1);
    advance();
    chk("t4_val", line_value_a, 45);
    chk("t4_done", done_a, 1);
    in_valid = 1'b1;
    char_in  = "9";
    for (int i = 0; i < 4; i++) begin
      advance();
      chk("t4_rdy", in_ready_a, 0);
      chk("t4_lv", line_valid_a, 0);
      chk("t4_cnt", line_count_a, 1);
      chk("t4_hold", done_a, 1);
    end
    in_valid = 1'b0;

    // Narrow accumulator wraps and overflow sticks.
    do_reset();
    for (int i = 0; i < 3; i++) send_line("99\n", 1'b0);
    advance();
    chk("t5_res", result_c, 41);
    chk("t5_ovf", overflow_c, 1);
    send_line("1\n", 1'b0);
    advance();
    chk("t5_sticky", overflow_c, 1);
    chk("t5_res2", result_c, 52);

    // Reset mid-line, then back-to-back lines with in_valid held.
    do_reset();
    send_line("7ab", 1'b0);
    do_reset();
    send_line("3\n", 1'b0);
    advance();
    chk("t6_val", line_value_a, 33);
    chk("t6_cnt", line_count_a, 1);
    send_line("12\n34\nfive6\n", 1'b0);

    // Randomised lines streamed against the model.
    for (int n = 0; n < 40; n++) begin
      int len = $urandom_range(0, 10);
      for (int j = 0; j < len; j++)
        step(pool[$urandom_range(0, pool.len() - 1)], 1'b0);
      step(LF, 1'b0);
      if ($urandom_range(0, 3) == 0) advance();
    end
    advance();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
